// File: rtl/cursor_control.sv
// Cursor/viewport controller: synchronised and debounced buttons drive per-direction auto-repeat FSMs that step a
// toroidal 512x512 cursor, with a view window that follows it, click pulses (btnc or paint mode) and a speed latch.
module cursor_control #(
  parameter int LOG_DEBOUNCE_COUNT = 20,
  parameter int LOG_WAIT_COUNT     = 25,
  parameter int VIEW_W             = 80,
  parameter int VIEW_H             = 60
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        btnu_in,
  input  logic        btnd_in,
  input  logic        btnl_in,
  input  logic        btnr_in,
  input  logic        btnc_in,
  input  logic [15:0] sw_in,
  input  logic        logic_done_in,
  output logic [8:0]  cursor_x_out,
  output logic [8:0]  cursor_y_out,
  output logic [8:0]  view_x_out,
  output logic [8:0]  view_y_out,
  output logic        click_out,
  output logic [3:0]  speed_out
);

  typedef enum logic [1:0] {IDLE, MOVE, HOLD} dir_state_t;

  localparam logic [8:0] VW = VIEW_W[8:0];
  localparam logic [8:0] VH = VIEW_H[8:0];

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 centre, 5 paint switch.
  logic [5:0] raw, sync1, sync2, level, level_q, press;
  logic [3:0] spd1, spd2;
  logic [LOG_DEBOUNCE_COUNT-1:0] db_cnt [6];

  dir_state_t state [4];
  dir_state_t nxt   [4];
  logic [LOG_WAIT_COUNT-1:0] hold_cnt [4];
  logic [3:0] block, step;

  logic [8:0] nx, ny, dx, dy, nvx, nvy;
  logic       unused_sw;

  assign raw       = {sw_in[14], btnc_in, btnr_in, btnl_in, btnd_in, btnu_in};
  assign unused_sw = ^{sw_in[15], sw_in[13:4]};
  assign press     = level & ~level_q;
  assign block     = {level[2], level[3], level[0], level[1]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1   <= '0;
      sync2   <= '0;
      spd1    <= '0;
      spd2    <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      spd1    <= sw_in[3:0];
      spd2    <= spd1;
      level_q <= level;
      // Any sample that agrees with the current level restarts the count.
      for (int i = 0; i < 6; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (&db_cnt[i]) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 4; i++) begin
        state[i]    <= IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i]    <= nxt[i];
        hold_cnt[i] <= (state[i] == HOLD && nxt[i] == HOLD) ? hold_cnt[i] + 1'b1 : '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nxt[i]  = state[i];
      step[i] = 1'b0;
      case (state[i])
        IDLE: if (press[i]) nxt[i] = MOVE;
        MOVE: begin
          nxt[i]  = HOLD;
          step[i] = 1'b1;
        end
        HOLD: if (&hold_cnt[i]) nxt[i] = MOVE;
        default: nxt[i] = IDLE;
      endcase
      // Release or an opposing press parks the direction and suppresses its step.
      if (!level[i] || block[i]) begin
        nxt[i]  = IDLE;
        step[i] = 1'b0;
      end
    end
  end

  always_comb begin
    nx = cursor_x_out;
    ny = cursor_y_out;
    if (step[3])      nx = cursor_x_out + 9'd1;
    else if (step[2]) nx = cursor_x_out - 9'd1;
    if (step[1])      ny = cursor_y_out + 9'd1;
    else if (step[0]) ny = cursor_y_out - 9'd1;
    dx  = nx - view_x_out;
    dy  = ny - view_y_out;
    nvx = view_x_out;
    nvy = view_y_out;
    if (dx == 9'h1FF)  nvx = view_x_out - 9'd1;
    else if (dx == VW) nvx = view_x_out + 9'd1;
    if (dy == 9'h1FF)  nvy = view_y_out - 9'd1;
    else if (dy == VH) nvy = view_y_out + 9'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cursor_x_out <= '0;
      cursor_y_out <= '0;
      view_x_out   <= '0;
      view_y_out   <= '0;
      click_out    <= 1'b0;
      speed_out    <= '0;
    end else begin
      cursor_x_out <= nx;
      cursor_y_out <= ny;
      view_x_out   <= nvx;
      view_y_out   <= nvy;
      // Paint clicks land in the same cycle the cursor moves.
      click_out    <= press[4] | (level[5] & (|step));
      if (logic_done_in) speed_out <= spd2;
    end
  end

endmodule

// File: tb/tb_cursor_control.sv
// Scoreboard bench for cursor_control with short debounce/repeat intervals.
module tb_cursor_control;

  localparam int LD = 2;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnu = 0, btnd = 0, btnl = 0, btnr = 0, btnc = 0, done = 0;
  logic [15:0] sw = '0;
  logic [8:0] cx, cy, vx, vy;
  logic click;
  logic [3:0] speed;

  cursor_control #(.LOG_DEBOUNCE_COUNT(LD), .LOG_WAIT_COUNT(LW), .VIEW_W(80), .VIEW_H(60)) dut (
    .clk_in(clk), .rst_in(rst), .btnu_in(btnu), .btnd_in(btnd), .btnl_in(btnl), .btnr_in(btnr),
    .btnc_in(btnc), .sw_in(sw), .logic_done_in(done), .cursor_x_out(cx), .cursor_y_out(cy),
    .view_x_out(vx), .view_y_out(vy), .click_out(click), .speed_out(speed)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [8:0] x, y, vx, vy; } pos4_t;
  typedef struct packed { pos4_t p; logic clk; logic [31:0] cyc; } ev_t;

  pos4_t exp_q[$];
  ev_t   obs_q[$];
  pos4_t prev, e;
  ev_t   o;
  int    cyc = 0, clicks = 0, n_cmp = 0, n_fail = 0;
  int    mx, my, mvx, mvy;

  always @(posedge clk) cyc++;

  // Monitor: every change of the cursor/view outputs becomes one observed event.
  always @(negedge clk) begin
    pos4_t cur;
    cur = {cx, cy, vx, vy};
    if (!rst && cur !== prev) obs_q.push_back({cur, click, cyc[31:0]});
    if (!rst && click === 1'b1) clicks++;
    prev = cur;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && obs_q.size() < n; i++) tick(1);
    ok = (obs_q.size() >= n);
  endtask

  // Reference: cursor wraps mod 512; the window slides one cell toward a cursor that left it.
  task automatic model_step(input int sx, input int sy);
    pos4_t p;
    mx = (mx + sx) & 511;
    my = (my + sy) & 511;
    if (((mx - mvx) & 511) >= 80) mvx = (mvx + sx) & 511;
    if (((my - mvy) & 511) >= 60) mvy = (mvy + sy) & 511;
    p.x = mx[8:0]; p.y = my[8:0]; p.vx = mvx[8:0]; p.vy = mvy[8:0];
    exp_q.push_back(p);
  endtask

  task automatic do_reset();
    btnu = 0; btnd = 0; btnl = 0; btnr = 0; btnc = 0; done = 0; sw = '0;
    rst = 1;
    tick(3);
    rst = 0;
    exp_q.delete(); obs_q.delete(); clicks = 0;
    mx = 0; my = 0; mvx = 0; mvy = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(3);
    n_cmp++;
    if ({cx, cy, vx, vy, click, speed} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got x=%0d y=%0d vx=%0d vy=%0d click=%b speed=%0d, want all 0", cx, cy, vx, vy, click, speed);
    end
    do_reset();
    tick(8);
    n_cmp++;
    if ({cx, cy, vx, vy, click, speed} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got x=%0d y=%0d vx=%0d vy=%0d click=%b speed=%0d, want all 0", cx, cy, vx, vy, click, speed);
    end
  endtask

  task automatic test_debounce();
    do_reset();
    btnr = 1; tick(3); btnr = 0; tick(20);
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_no_move: got %0d moves, want 0", obs_q.size()); end
    obs_q.delete();
    model_step(1, 0);
    btnr = 1; tick(10); btnr = 0; tick(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL debounce_step: got no move, want x=%0d vx=%0d", e.x, e.vx);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e) begin
          n_fail++;
          $display("FAIL debounce_step: got x=%0d y=%0d vx=%0d vy=%0d, want x=%0d y=%0d vx=%0d vy=%0d",
                   o.p.x, o.p.y, o.p.vx, o.p.vy, e.x, e.y, e.vx, e.vy);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL debounce_extra: got %0d extra moves, want 0", obs_q.size()); end
  endtask

  task automatic test_repeat();
    logic [31:0] last;
    int k;
    do_reset();
    repeat (3) model_step(-1, 0);
    btnl = 1; tick(40); btnl = 0; tick(30);
    k = 0; last = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL repeat_step: got no move, want x=%0d vx=%0d", e.x, e.vx);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e) begin
          n_fail++;
          $display("FAIL repeat_step: got x=%0d y=%0d vx=%0d vy=%0d, want x=%0d y=%0d vx=%0d vy=%0d",
                   o.p.x, o.p.y, o.p.vx, o.p.vy, e.x, e.y, e.vx, e.vy);
        end
        if (k > 0) begin
          n_cmp++;
          if (o.cyc - last !== 32'd17) begin n_fail++; $display("FAIL repeat_period: got %0d cycles, want 17", o.cyc - last); end
        end
        last = o.cyc; k++;
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL repeat_extra: got %0d extra moves, want 0", obs_q.size()); end
  endtask

  task automatic test_view_diagonal();
    bit ok;
    do_reset();
    repeat (80) model_step(1, 1);
    btnr = 1; btnd = 1;
    wait_obs(80, 80 * 17 + 100, ok);
    btnr = 0; btnd = 0; tick(30);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL view_timeout: got %0d moves, want 80", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL view_step: got no move, want x=%0d y=%0d", e.x, e.y);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e) begin
          n_fail++;
          $display("FAIL view_step: got x=%0d y=%0d vx=%0d vy=%0d, want x=%0d y=%0d vx=%0d vy=%0d",
                   o.p.x, o.p.y, o.p.vx, o.p.vy, e.x, e.y, e.vx, e.vy);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL view_extra: got %0d extra moves, want 0", obs_q.size()); end
  endtask

  task automatic test_opposing_click();
    do_reset();
    btnu = 1; btnd = 1; tick(30); btnu = 0; btnd = 0; tick(20);
    n_cmp++;
    if (obs_q.size() != 0 || cy !== 9'd0) begin
      n_fail++; $display("FAIL opposing_no_move: got %0d moves y=%0d, want 0 moves y=0", obs_q.size(), cy);
    end
    btnc = 1; tick(30); btnc = 0; tick(20);
    n_cmp++;
    if (clicks != 1) begin n_fail++; $display("FAIL click_once: got %0d pulses, want 1", clicks); end
  endtask

  task automatic test_paint_speed();
    do_reset();
    sw[14] = 1; tick(12);
    n_cmp++;
    if (clicks != 0) begin n_fail++; $display("FAIL paint_idle_click: got %0d pulses, want 0", clicks); end
    repeat (3) model_step(1, 0);
    btnr = 1; tick(40); btnr = 0; tick(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL paint_step: got no move, want x=%0d", e.x);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e || o.clk !== 1'b1) begin
          n_fail++;
          $display("FAIL paint_step: got x=%0d vx=%0d click=%b, want x=%0d vx=%0d click=1", o.p.x, o.p.vx, o.clk, e.x, e.vx);
        end
      end
    end
    n_cmp++;
    if (clicks != 3 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL paint_clicks: got %0d pulses %0d extra moves, want 3 pulses 0 extra", clicks, obs_q.size());
    end
    sw[3:0] = 4'h9; tick(10);
    n_cmp++;
    if (speed !== 4'h0) begin n_fail++; $display("FAIL speed_hold: got %0d, want 0", speed); end
    done = 1;
    @(negedge clk);
    n_cmp++;
    if (speed !== 4'h0) begin n_fail++; $display("FAIL speed_early: got %0d, want 0", speed); end
    @(posedge clk); #2; done = 0;
    @(negedge clk);
    n_cmp++;
    if (speed !== 4'h9) begin n_fail++; $display("FAIL speed_load: got %0d, want 9", speed); end
    sw[3:0] = 4'h4; tick(10);
    n_cmp++;
    if (speed !== 4'h9) begin n_fail++; $display("FAIL speed_keep: got %0d, want 9", speed); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int rel;
    do_reset();
    repeat (5) model_step(1, 1);
    btnr = 1; btnd = 1;
    wait_obs(5, 300, ok);
    btnr = 0;
    repeat (2) model_step(0, 1);
    wait_obs(7, 300, ok);
    tick(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL arst_setup: got no move, want x=%0d y=%0d", e.x, e.y);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e) begin
          n_fail++; $display("FAIL arst_setup: got x=%0d y=%0d, want x=%0d y=%0d", o.p.x, o.p.y, e.x, e.y);
        end
      end
    end
    #1 rst = 1;
    #1;
    n_cmp++;
    if ({cx, cy, vx, vy, click, speed} !== '0) begin
      n_fail++; $display("FAIL arst_immediate: got x=%0d y=%0d vx=%0d vy=%0d, want all 0", cx, cy, vx, vy);
    end
    tick(2);
    rst = 0; rel = cyc;
    obs_q.delete(); clicks = 0;
    mx = 0; my = 0; mvx = 0; mvy = 0;
    model_step(0, 1);
    tick(12); btnd = 0; tick(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL arst_rearm: got no move, want y=%0d", e.y);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e || int'(o.cyc) - rel < (1 << LD) + 2) begin
          n_fail++;
          $display("FAIL arst_rearm: got x=%0d y=%0d after %0d cycles, want x=%0d y=%0d after >=%0d", o.p.x, o.p.y,
                   int'(o.cyc) - rel, e.x, e.y, (1 << LD) + 2);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL arst_extra: got %0d extra moves, want 0", obs_q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    test_debounce();
    test_repeat();
    test_view_diagonal();
    test_opposing_click();
    test_paint_speed();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cursor_control.md
CURSOR_CONTROL -- requirements
Module: cursor_control

Interface
REQ-001 SHALL have parameter LOG_DEBOUNCE_COUNT, default 20: button must be stable 2^LOG_DEBOUNCE_COUNT cycles to register.
REQ-002 SHALL have parameter LOG_WAIT_COUNT, default 25: auto-repeat period while a direction button is held is 2^LOG_WAIT_COUNT cycles.
REQ-003 SHALL have parameter VIEW_W, default 80: visible cells horizontally.
REQ-004 SHALL have parameter VIEW_H, default 60: visible cells vertically.
REQ-005 clk_in  input  1  system clock (100 MHz); one clock, all state on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous and active-high.
REQ-007 btnu_in, btnd_in, btnl_in, btnr_in, btnc_in  input  1 each  raw asynchronous pushbuttons.
REQ-008 sw_in  input  16  raw switches; sw_in[3:0] requested speed, sw_in[14] paint mode.
REQ-009 logic_done_in  input  1  one-cycle pulse, generation finished.
REQ-010 cursor_x_out, cursor_y_out  output  9 (pos_t)  cursor cell, board 512x512, toroidal.
REQ-011 view_x_out, view_y_out  output  9 (pos_t)  top-left cell of visible window.
REQ-012 click_out  output  1  one-cycle toggle request for the cell at the cursor.
REQ-013 speed_out  output  4 (speed_t)  speed applied by life logic.

Function
REQ-014 Each button and sw_in[14] SHALL pass a 2-flop synchronizer, then a debouncer; debounced level changes only after the synchronized input differs from it for 2^LOG_DEBOUNCE_COUNT consecutive cycles; any glitch restarts the count.
REQ-015 Per direction SHALL run FSM IDLE -> (press edge) MOVE -> HOLD; MOVE lasts one cycle and issues one step; HOLD counts 2^LOG_WAIT_COUNT cycles then returns to MOVE; debounced release in any state -> IDLE with counter cleared.
REQ-016 Up step SHALL be cursor_y-1, down +1, left cursor_x-1, right +1, all modulo 512 (0-1=511, 511+1=0).
REQ-017 Up and down both debounced-pressed SHALL produce no y step and hold both FSMs in IDLE; same for left/right on x; x and y steps in the same cycle (diagonal) SHALL both apply.
REQ-018 Cursor outputs SHALL update the cycle after MOVE (1-cycle latency from MOVE).
REQ-019 View tracking per axis, d=(cursor-view) mod 512 after a step: d==511 -> view-1; d==VIEW_W (x) or VIEW_H (y) -> view+1; else unchanged; modulo 512; view updates in the same cycle as cursor.
REQ-020 click_out SHALL pulse one cycle on each debounced btnc press edge; held btnc gives no further pulses.
REQ-021 With debounced sw_in[14]=1, click_out SHALL also pulse one cycle in the cycle cursor outputs change; coincident btnc edge yields a single pulse.
REQ-022 speed_out SHALL load sw_in[3:0] (2-flop synchronized) only in the cycle after logic_done_in=1; otherwise hold.

Reset
REQ-023 rst_in=1 SHALL immediately force cursor and view outputs to 0, click_out 0, speed_out 0, all FSMs IDLE, debounced levels 0, all counters 0, regardless of clock.
REQ-024 Reset mid-hold or mid-debounce SHALL discard progress; a button held through reset release SHALL need a full debounce interval then register one press edge.

Verification (LOG_DEBOUNCE_COUNT=2, LOG_WAIT_COUNT=4)
REQ-025 Reset, btnr high 3 cycles then low -> no move; high 10 cycles -> cursor_x 0->1 exactly once, view_x stays 0.
REQ-026 From reset, btnl held 40 cycles -> cursor_x 511 after first MOVE, then decrement every 17 cycles (16 HOLD + MOVE); view_x 511 then 510, ... tracking.
REQ-027 Cursor_x stepped right 0->80 -> view_x becomes 1 at the step to 80; cursor_y stepped to 60 -> view_y 1.
REQ-028 btnu and btnd pressed together 30 cycles -> cursor_y unchanged; btnc held 30 cycles -> exactly one click_out pulse.
REQ-029 sw_in[14]=1, btnr held -> click_out pulse in each cycle cursor_x changes; sw_in[3:0]=4'h9 -> speed_out stays 0 until logic_done_in pulse, then 9 one cycle later.
REQ-030 Assert rst_in asynchronously mid-HOLD with cursor (5,7) -> outputs 0 before next clock edge; button still held after release -> one step after debounce.
